// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared types and constants for the elastic inter-stage pipeline register
package pipe_stage_reg_pkg;
    localparam int EXC_W = 6;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    typedef logic [EXC_W-1:0] ExceptinPipeType;
    typedef enum logic [1:0] {EMPTY, FULL, SKID} stage_state_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear taking priority over increment
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr ? '0 : (inc && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;

    assign cnt = cnt_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline register with valid/ready, optional skid entry, flush and stall counter
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int          DATA_W   = 64,
    parameter int          EXC_W    = pipe_stage_reg_pkg::EXC_W,
    parameter logic [31:0] RESET_PC = pipe_stage_reg_pkg::RESET_PC,
    parameter int          SKID_EN  = 1,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic [EXC_W-1:0]  in_exc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_has_exc,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              clr_cnt
);
    stage_state_e      state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [31:0]       pc_q, pc_d, skid_pc_q, skid_pc_d;
    logic [DATA_W-1:0] data_q, data_d, skid_data_q, skid_data_d;
    logic [EXC_W-1:0]  exc_q, exc_d, skid_exc_q, skid_exc_d;
    logic              accept, deliver, load_main, load_skid, from_skid;

    assign out_valid   = state_q != EMPTY;
    assign in_ready    = (SKID_EN != 0) ? in_ready_q : (out_ready || !out_valid);
    assign out_pc      = pc_q;
    assign out_data    = data_q;
    assign out_exc     = exc_q;
    assign out_has_exc = out_valid && (|exc_q);

    always_comb begin
        accept      = in_valid && in_ready;
        deliver     = out_valid && out_ready;
        state_d     = flush ? EMPTY
                    : (state_q == EMPTY) ? (accept ? FULL : EMPTY)
                    : (state_q == FULL)  ? ((accept && !deliver && SKID_EN != 0) ? SKID
                                           : (!accept && deliver) ? EMPTY : FULL)
                    : (deliver ? FULL : SKID);
        in_ready_d  = state_d != SKID;
        from_skid   = state_q == SKID;
        load_main   = !flush && ((state_q == EMPTY) ? accept
                                 : (state_q == FULL) ? (accept && deliver) : deliver);
        load_skid   = !flush && state_q == FULL && accept && !deliver;
        pc_d        = load_main ? (from_skid ? skid_pc_q   : in_pc)   : pc_q;
        data_d      = load_main ? (from_skid ? skid_data_q : in_data) : data_q;
        exc_d       = load_main ? (from_skid ? skid_exc_q  : in_exc)  : exc_q;
        skid_pc_d   = load_skid ? in_pc   : skid_pc_q;
        skid_data_d = load_skid ? in_data : skid_data_q;
        skid_exc_d  = load_skid ? in_exc  : skid_exc_q;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            pc_q        <= RESET_PC;
            data_q      <= '0;
            exc_q       <= '0;
            skid_pc_q   <= RESET_PC;
            skid_data_q <= '0;
            skid_exc_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            pc_q        <= pc_d;
            data_q      <= data_d;
            exc_q       <= exc_d;
            skid_pc_q   <= skid_pc_d;
            skid_data_q <= skid_data_d;
            skid_exc_q  <= skid_exc_d;
        end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid && !out_ready && !flush),
        .clr (clr_cnt),
        .cnt (stall_cnt)
    );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random traffic against a queue-based reference model
module tb_pipe_stage_reg;
    logic        clk = 0, rst = 0, flush = 0, in_valid = 0, out_ready = 0, clr_cnt = 0;
    logic [31:0] in_pc = 0;
    logic [63:0] in_data = 0;
    logic [5:0]  in_exc = 0;
    logic        in_ready, out_valid, out_has_exc;
    logic [31:0] out_pc;
    logic [63:0] out_data;
    logic [5:0]  out_exc;
    logic [15:0] stall_cnt;

    typedef struct packed {logic [31:0] pc; logic [63:0] data; logic [5:0] exc;} ent_t;
    ent_t q[$];
    int   mcnt = 0, checks = 0, errors = 0;

    pipe_stage_reg dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data), .in_exc(in_exc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_data(out_data),
        .out_exc(out_exc), .out_has_exc(out_has_exc), .stall_cnt(stall_cnt), .clr_cnt(clr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Model: occupancy is the queue length; a stage holds at most two entries.
    always @(negedge clk) if (rst) begin
        bit mv, mr;
        mv = q.size() != 0;
        mr = q.size() < 2;
        chk("out_valid", out_valid, mv);
        chk("in_ready", in_ready, mr);
        chk("stall_cnt", stall_cnt, mcnt);
        if (mv) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_data", out_data, q[0].data);
            chk("out_exc", out_exc, q[0].exc);
            chk("out_has_exc", out_has_exc, |q[0].exc);
        end else
            chk("has_exc_idle", out_has_exc, 0);
        if (mv && out_ready) void'(q.pop_front());
        if (in_valid && mr && !flush) q.push_back('{pc: in_pc, data: in_data, exc: in_exc});
        if (flush) q.delete();
        if (clr_cnt) mcnt = 0;
        else if (mv && !out_ready && !flush && mcnt < 65535) mcnt++;
    end

    initial begin
        @(posedge clk);
        #1 rst = 1;
        repeat (2) cyc();
        // back-to-back with no bubbles
        out_ready = 1;
        in_valid  = 1;
        for (int i = 0; i < 3; i++) begin
            in_pc   = 32'h100 + 32'(4 * i);
            in_data = {$urandom, $urandom};
            cyc();
            chk("b2b_pc", out_pc, 32'h100 + 32'(4 * i));
            chk("b2b_valid", out_valid, 1);
        end
        in_valid = 0;
        cyc();
        // skid fill and ordered drain
        out_ready = 0;
        in_valid  = 1;
        in_pc     = 32'h200;
        cyc();
        in_pc = 32'h204;
        cyc();
        chk("skid_in_ready", in_ready, 0);
        chk("skid_head", out_pc, 32'h200);
        in_valid  = 0;
        out_ready = 1;
        cyc();
        chk("skid_second", out_pc, 32'h204);
        cyc();
        chk("skid_drained", out_valid, 0);
        // flush while both entries are held
        out_ready = 0;
        in_valid  = 1;
        in_pc     = 32'h2F0;
        cyc();
        in_pc = 32'h2F4;
        cyc();
        in_pc = 32'h300;
        flush = 1;
        cyc();
        flush    = 0;
        in_valid = 0;
        chk("flush_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        out_ready = 1;
        repeat (3) cyc();
        chk("flush_no_300", out_valid, 0);
        // exception flags carried verbatim
        out_ready = 0;
        in_valid  = 1;
        in_pc     = 32'h400;
        in_exc    = 6'b000100;
        cyc();
        in_valid = 0;
        in_exc   = 0;
        chk("exc_vec", out_exc, 6'b000100);
        chk("exc_flag", out_has_exc, 1);
        out_ready = 1;
        cyc();
        chk("exc_flag_after", out_has_exc, 0);
        // asynchronous reset in mid-cycle while full
        out_ready = 0;
        in_valid  = 1;
        in_pc     = 32'h600;
        cyc();
        in_pc = 32'h604;
        cyc();
        #2 rst = 0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_pc", out_pc, 32'hBFC0_0000);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_data", out_data, 0);
        chk("rst_cnt", stall_cnt, 0);
        q.delete();
        mcnt     = 0;
        in_valid = 0;
        @(posedge clk);
        #1 rst = 1;
        cyc();
        // stall counter saturation and clear
        in_valid = 1;
        in_pc    = 32'h500;
        cyc();
        in_valid = 0;
        repeat (65600) cyc();
        chk("cnt_sat", stall_cnt, 16'hFFFF);
        clr_cnt = 1;
        cyc();
        clr_cnt = 0;
        chk("cnt_clr", stall_cnt, 0);
        out_ready = 1;
        repeat (2) cyc();
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = 1'($urandom % 2);
            in_pc     = $urandom;
            in_data   = {$urandom, $urandom};
            in_exc    = 6'($urandom);
            out_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 32) == 0;
            clr_cnt   = ($urandom % 64) == 0;
            cyc();
        end
        in_valid  = 0;
        flush     = 0;
        clr_cnt   = 0;
        out_ready = 1;
        repeat (4) cyc();
        chk("drain_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, elastic inter-stage pipeline register: the next generation of the fixed PC/stage register interface.
- Carries PC, a generic payload and the in-pipe exception vector between any two adjacent stages (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
- Adds a valid/ready handshake, a one-entry skid buffer so the ready path is fully registered, synchronous flush, and a saturating stall counter.

Parameters:
- DATA_W, 64, payload width in bits (decoded controls and operands); must be ≥1.
- EXC_W, 6, exception vector width; matches ExceptinPipeType.
- RESET_PC, 32'hBFC0_0000, value of out_pc during and after reset.
- SKID_EN, 1, 1 = two-entry skid buffer; 0 = single register with in_ready combinationally equal to (out_ready | !out_valid).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  discard all held and incoming entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept this cycle.
- in_pc  in  32  PC of incoming entry.
- in_data  in  DATA_W  payload.
- in_exc  in  EXC_W  exception flags of incoming entry.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts.
- out_pc  out  32  PC of presented entry.
- out_data  out  DATA_W  payload of presented entry.
- out_exc  out  EXC_W  exception flags of presented entry.
- out_has_exc  out  1  OR-reduction of out_exc, gated by out_valid.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.
- clr_cnt  in  1  synchronous clear of stall_cnt.

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0, skid entry invalid, out_pc=RESET_PC, out_data=0, out_exc=0, out_has_exc=0, stall_cnt=0; in_ready=1 immediately. Reset mid-transfer drops both held entries without completing the handshake.
- Transfers: accept when in_valid & in_ready; deliver when out_valid & out_ready. Latency is one cycle from accept to out_valid with an empty stage.
- State (SKID_EN=1): EMPTY (nothing held), FULL (main register valid), SKID (main and skid both valid).
  - EMPTY + accept -> FULL.
  - FULL + accept + deliver -> FULL, main loaded from input.
  - FULL + accept without deliver -> SKID, input captured in skid register.
  - FULL + deliver without accept -> EMPTY.
  - SKID + deliver -> FULL, main loaded from skid.
- in_ready is a flop equal to !(next state == SKID); it never depends on out_ready in the same cycle.
- SKID_EN=0: only EMPTY/FULL exist; in_ready = out_ready | !out_valid.
- Ordering: entries leave strictly in acceptance order; no entry is duplicated or dropped except on flush.
- Flush: highest priority. Next state is EMPTY regardless of in_valid/out_ready. An input offered in the flush cycle is not captured; a same-cycle deliver is still counted as delivered by downstream. out_pc/out_data/out_exc hold their last values (don't-care while out_valid=0).
- Exceptions: out_exc is carried verbatim; the stage never creates or clears flags. out_has_exc=0 whenever out_valid=0.
- stall_cnt: increments by 1 when out_valid & !out_ready and no flush; saturates at all-ones; clr_cnt has priority over increment; flush does not clear it.
- Data registers load only on capture (clock-enable style); no X leakage after reset.

Decomposition:
- The shared package holds ExceptinPipeType, its width constant EXC_W, the RESET_PC constant and the stage-state enum {EMPTY, FULL, SKID}.
- Natural sub-module: sat_counter (CNT_W, inc, clr), reused by later performance counters.
- Register and skid logic stay in pipe_stage_reg.

Test Plan:
- Reset: assert rst=0 mid-cycle -> out_valid=0, out_pc=32'hBFC0_0000 and in_ready=1 asynchronously, before the next edge.
- Back-to-back: in_valid=1, out_ready=1, PCs 0x100, 0x104, 0x108 -> out_pc shows the same sequence one cycle later, with no bubbles.
- Skid: fill with 0x200; hold out_ready=0 and offer 0x204 -> in_ready falls next cycle. Release out_ready -> 0x200 then 0x204 delivered, in order.
- Flush in SKID state with in_valid=1 at PC 0x300 -> next cycle out_valid=0 and in_ready=1; 0x300 never appears.
- Exception: in_exc=6'b000100 at PC 0x400 -> out_exc=6'b000100 and out_has_exc=1 for that entry only; out_has_exc=0 after delivery.
- Counter: hold out_valid=1, out_ready=0 for 70000 cycles with CNT_W=16 -> stall_cnt saturates at 0xFFFF. clr_cnt=1 -> 0 next cycle.
